// File: rtl/broadcast_pkg.sv
// Shared sizing helpers for the pipelined broadcast tree.
// Every function here is a constant function, so RTL and bench use them to size levels.
package broadcast_pkg;

  function automatic int ipow(input int base, input int expo);
    int r;
    r = 1;
    for (int i = 0; i < expo; i++) r = r * base;
    return r;
  endfunction

  // Smallest d >= 1 such that fanout^d reaches nodes.
  function automatic int tree_depth(input int nodes, input int fanout);
    int d;
    int p;
    d = 1;
    p = fanout;
    while (p < nodes) begin
      p = p * fanout;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic int level_width(input int nodes, input int fanout, input int level);
    int div;
    div = ipow(fanout, tree_depth(nodes, fanout) - level);
    return (nodes + div - 1) / div;
  endfunction

  // Index of the first register of a level in the flattened register array.
  function automatic int level_offset(input int nodes, input int fanout, input int level);
    int off;
    off = 0;
    for (int l = 1; l < level; l++) off = off + level_width(nodes, fanout, l);
    return off;
  endfunction

endpackage

// File: rtl/broadcast_stage.sv
// One tree register: a valid bit plus its payload, with synchronous valid flush.
module broadcast_stage #(
  parameter int MESSAGE_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_vld,
  input  logic [MESSAGE_WIDTH-1:0] i_data,
  output logic                     o_vld,
  output logic [MESSAGE_WIDTH-1:0] o_data
);

  logic                     r_vld;
  logic [MESSAGE_WIDTH-1:0] r_data;

  // Payload is captured every cycle; flush only touches the valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld  <= i_vld & ~i_flush;
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/pipelined_broadcast_tree.sv
// Registered fanout tree copying one message to NODES outputs, each register driving
// at most MAX_FANOUT registers, with a fixed latency of DEPTH cycles.
module pipelined_broadcast_tree
  import broadcast_pkg::*;
#(
  parameter int MESSAGE_WIDTH = 16,
  parameter int MAX_FANOUT    = 3,
  parameter int NODES         = 100,
  localparam int DEPTH        = tree_depth(NODES, MAX_FANOUT),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [MESSAGE_WIDTH-1:0] message,
  input  logic                     message_valid,
  output logic [MESSAGE_WIDTH-1:0] outputs [0:NODES-1],
  output logic [NODES-1:0]         output_valids,
  output logic [CNT_W-1:0]         in_flight,
  output logic                     idle
);

  localparam int TOTAL    = level_offset(NODES, MAX_FANOUT, DEPTH + 1);
  localparam int LEAF_OFF = level_offset(NODES, MAX_FANOUT, DEPTH);

  logic [TOTAL-1:0]         w_vld;
  logic [MESSAGE_WIDTH-1:0] w_data [TOTAL];
  logic                     w_leaf_vld;
  logic [CNT_W-1:0]         r_in_flight;

  for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
    localparam int OFF = level_offset(NODES, MAX_FANOUT, l);
    for (genvar j = 0; j < level_width(NODES, MAX_FANOUT, l); j++) begin : g_reg
      logic                     w_src_vld;
      logic [MESSAGE_WIDTH-1:0] w_src_data;
      if (l == 1) begin : g_root
        assign w_src_vld  = message_valid;
        assign w_src_data = message;
      end else begin : g_child
        localparam int PARENT = level_offset(NODES, MAX_FANOUT, l - 1) + j / MAX_FANOUT;
        assign w_src_vld  = w_vld[PARENT];
        assign w_src_data = w_data[PARENT];
      end
      broadcast_stage #(.MESSAGE_WIDTH(MESSAGE_WIDTH)) u_stage (
        .clock  (clock),
        .reset  (reset),
        .i_flush(flush),
        .i_vld  (w_src_vld),
        .i_data (w_src_data),
        .o_vld  (w_vld[OFF + j]),
        .o_data (w_data[OFF + j])
      );
    end
  end

  for (genvar i = 0; i < NODES; i++) begin : g_out
    assign outputs[i]       = w_data[LEAF_OFF + i];
    assign output_valids[i] = w_vld[LEAF_OFF + i];
  end

  // All leaf valids are identical, so any one marks a message leaving the tree.
  assign w_leaf_vld = w_vld[LEAF_OFF];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_flight <= '0;
    end else if (flush) begin
      r_in_flight <= '0;
    end else if (message_valid && !w_leaf_vld) begin
      r_in_flight <= r_in_flight + CNT_W'(1);
    end else if (!message_valid && w_leaf_vld) begin
      r_in_flight <= r_in_flight - CNT_W'(1);
    end
  end

  assign in_flight = r_in_flight;
  assign idle      = (r_in_flight == '0);

endmodule

// File: tb/tb_pipelined_broadcast_tree.sv
// Self-checking bench: main tree NODES=10/FANOUT=3 plus boundary-size trees on shared inputs.
module tb_pipelined_broadcast_tree;
  import broadcast_pkg::*;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] msg;
  logic        mv;

  logic [15:0] out10 [0:9];
  logic [9:0]  ov10;
  logic [1:0]  if10;
  logic        idle10;

  logic [15:0] out1 [0:0];
  logic [0:0]  ov1;
  logic [0:0]  if1;
  logic        idle1;
  logic [15:0] out9 [0:8];
  logic [8:0]  ov9;
  logic [1:0]  if9;
  logic        idle9;
  logic [15:0] out27 [0:26];
  logic [26:0] ov27;
  logic [1:0]  if27;
  logic        idle27;
  logic [15:0] out28 [0:27];
  logic [27:0] ov28;
  logic [2:0]  if28;
  logic        idle28;

  int   tests;
  int   fails;
  int   cyc;
  exp_t sb [$];

  pipelined_broadcast_tree #(.MESSAGE_WIDTH(16), .MAX_FANOUT(3), .NODES(10)) dut (
    .clock(clk), .reset(rst), .flush(flush), .message(msg), .message_valid(mv),
    .outputs(out10), .output_valids(ov10), .in_flight(if10), .idle(idle10));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(16), .MAX_FANOUT(3), .NODES(1)) u_n1 (
    .clock(clk), .reset(rst), .flush(flush), .message(msg), .message_valid(mv),
    .outputs(out1), .output_valids(ov1), .in_flight(if1), .idle(idle1));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(16), .MAX_FANOUT(3), .NODES(9)) u_n9 (
    .clock(clk), .reset(rst), .flush(flush), .message(msg), .message_valid(mv),
    .outputs(out9), .output_valids(ov9), .in_flight(if9), .idle(idle9));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(16), .MAX_FANOUT(3), .NODES(27)) u_n27 (
    .clock(clk), .reset(rst), .flush(flush), .message(msg), .message_valid(mv),
    .outputs(out27), .output_valids(ov27), .in_flight(if27), .idle(idle27));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(16), .MAX_FANOUT(3), .NODES(28)) u_n28 (
    .clock(clk), .reset(rst), .flush(flush), .message(msg), .message_valid(mv),
    .outputs(out28), .output_valids(ov28), .in_flight(if28), .idle(idle28));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) if (out10[i] !== 16'h0) bad++;
    tests++;
    if (ov10 !== 10'h0 || bad != 0) begin
      fails++;
      $display("FAIL reset_outputs: valids=%h nonzero_payloads=%0d, required valids=0 payloads=0", ov10, bad);
    end
    tests++;
    if (if10 !== 2'd0 || idle10 !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: in_flight=%0d idle=%b, required 0 and 1", if10, idle10);
    end
  endtask

  task automatic test_latency();
    int bad;
    msg = 16'hBEEF;
    mv  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      mv  = 1'b0;
      msg = 16'h0;
      tests++;
      if (ov10 !== ((k == 3) ? 10'h3FF : 10'h000)) begin
        fails++;
        $display("FAIL latency_valid cycle %0d: got %h, required %h", k, ov10, (k == 3) ? 10'h3FF : 10'h000);
      end
      if (k == 3) begin
        bad = 0;
        for (int i = 0; i < 10; i++) if (out10[i] !== 16'hBEEF) bad++;
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL latency_data: %0d outputs differ, out[0]=%h required BEEF", bad, out10[0]);
        end
      end
    end
  endtask

  task automatic test_streaming();
    exp_t e;
    int   bad;
    int   exp_if;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 8) begin
        msg = 16'(k);
        mv  = 1'b1;
        sb.push_back('{data: 16'(k), due: cyc + 3});
      end else begin
        mv = 1'b0;
      end
      tick();
      exp_if = ((k < 8) ? k : 8) - ((k - 3 < 0) ? 0 : ((k - 3 > 8) ? 8 : k - 3));
      tests++;
      if (if10 !== 2'(exp_if)) begin
        fails++;
        $display("FAIL stream_in_flight cycle %0d: got %0d, required %0d", k, if10, exp_if);
      end
      if (ov10 !== 10'h0) begin
        tests++;
        if (ov10 !== 10'h3FF) begin
          fails++;
          $display("FAIL stream_valids_equal: got %h, required 3ff", ov10);
        end
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL stream_unexpected: output %h at cycle %0d, required none", out10[0], k);
        end else begin
          e = sb.pop_front();
          bad = 0;
          for (int i = 0; i < 10; i++) if (out10[i] !== e.data) bad++;
          if (bad != 0 || e.due != cyc) begin
            fails++;
            $display("FAIL stream_data: got %h at cycle %0d (%0d differ), required %h at cycle %0d",
                     out10[0], cyc, bad, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        tests++;
        fails++;
        $display("FAIL stream_gap: no valid at cycle %0d, required %h", cyc, sb[0].data);
        void'(sb.pop_front());
      end
    end
    tests++;
    if (sb.size() != 0 || idle10 !== 1'b1) begin
      fails++;
      $display("FAIL stream_drain: pending=%0d idle=%b, required 0 and 1", sb.size(), idle10);
    end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      msg = 16'(16'hF000 + k);
      mv  = 1'b1;
      tick();
    end
    tests++;
    if (if10 !== 2'd3) begin
      fails++;
      $display("FAIL flush_preload: in_flight=%0d, required 3", if10);
    end
    msg   = 16'hF004;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mv    = 1'b0;
    tests++;
    if (if10 !== 2'd0 || idle10 !== 1'b1) begin
      fails++;
      $display("FAIL flush_count: in_flight=%0d idle=%b, required 0 and 1", if10, idle10);
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (ov10 !== 10'h0) begin
        fails++;
        $display("FAIL flush_leak: valids=%h data=%h after flush, required valids 0", ov10, out10[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    int bad;
    msg = 16'hAAAA;
    mv  = 1'b1;
    tick();
    msg = 16'hBBBB;
    tick();
    mv = 1'b0;
    tick();
    tests++;
    if (if10 !== 2'd2 || ov10 !== 10'h3FF) begin
      fails++;
      $display("FAIL midreset_preload: in_flight=%0d valids=%h, required 2 and 3ff", if10, ov10);
    end
    #2 rst = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) if (out10[i] !== 16'h0) bad++;
    tests++;
    if (ov10 !== 10'h0 || bad != 0 || if10 !== 2'd0 || idle10 !== 1'b1) begin
      fails++;
      $display("FAIL midreset_clear: valids=%h nonzero=%0d in_flight=%0d idle=%b, required 0/0/0/1",
               ov10, bad, if10, idle10);
    end
    tests++;
    if ({idle1, idle9, idle27, idle28} !== 4'hF || if1 !== 1'd0 || if9 !== 2'd0 || if27 !== 2'd0 || if28 !== 3'd0) begin
      fails++;
      $display("FAIL midreset_boundary_idle: idles=%b, required 1111", {idle1, idle9, idle27, idle28});
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    msg = 16'h1234;
    mv  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      mv = 1'b0;
      tests++;
      if (ov10 !== ((k == 3) ? 10'h3FF : 10'h000) || (k == 3 && out10[9] !== 16'h1234)) begin
        fails++;
        $display("FAIL midreset_after: cycle %0d valids=%h data=%h, required valid only at 3 with 1234",
                 k, ov10, out10[9]);
      end
    end
  endtask

  task automatic test_boundaries();
    int cnt [64];
    int ns [5];
    int n;
    int d;
    int bad;
    msg = 16'h5A5A;
    mv  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      mv = 1'b0;
      tests++;
      if (ov1 !== ((k == 1) ? 1'b1 : 1'b0) || (k == 1 && out1[0] !== 16'h5A5A)) begin
        fails++;
        $display("FAIL nodes1_latency: cycle %0d valid=%b data=%h, required valid only at 1", k, ov1, out1[0]);
      end
      tests++;
      if (ov9 !== ((k == 2) ? 9'h1FF : 9'h0) || (k == 2 && out9[8] !== 16'h5A5A)) begin
        fails++;
        $display("FAIL nodes9_latency: cycle %0d valids=%h data=%h, required valid only at 2", k, ov9, out9[8]);
      end
      tests++;
      if (ov27 !== ((k == 3) ? 27'h7FFFFFF : 27'h0) || (k == 3 && out27[26] !== 16'h5A5A)) begin
        fails++;
        $display("FAIL nodes27_latency: cycle %0d valids=%h data=%h, required valid only at 3", k, ov27, out27[26]);
      end
      tests++;
      if (ov28 !== ((k == 4) ? 28'hFFFFFFF : 28'h0) || (k == 4 && out28[27] !== 16'h5A5A)) begin
        fails++;
        $display("FAIL nodes28_latency: cycle %0d valids=%h data=%h, required valid only at 4", k, ov28, out28[27]);
      end
    end
    ns = '{1, 9, 10, 27, 28};
    for (int c = 0; c < 5; c++) begin
      n   = ns[c];
      d   = tree_depth(n, 3);
      bad = 0;
      if (level_width(n, 3, 1) > 3 || level_width(n, 3, d) != n) bad++;
      for (int l = 2; l <= d; l++) begin
        for (int p = 0; p < 64; p++) cnt[p] = 0;
        for (int j = 0; j < level_width(n, 3, l); j++) begin
          if (j / 3 >= level_width(n, 3, l - 1)) bad++;
          else cnt[j / 3]++;
        end
        for (int p = 0; p < 64; p++) if (cnt[p] > 3) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL fanout_structure nodes=%0d: %0d violations, required 0", n, bad);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    msg   = 16'h0;
    mv    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_latency();
    test_streaming();
    test_flush();
    test_reset_midstream();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
